// File: rtl/sample_tx_if.sv
// Sample serializer bus: controller word handshake plus UART byte handshake.
// Latency: none (signal bundle only).
// Backpressure: rdy_o gates word strobes; xrdy_i gates byte strobes.
//
// Ports (signals in the bundle):
//   stb_i   word strobe from the capture controller, sampled only while rdy_o=1
//   data_i  sample word, 8*NBYTES bits
//   dis_i   channel-group disable mask, bit i=1 skips byte i
//   rdy_o   serializer idle; drives the controller's tx-ready input
//   xdata_o byte to the UART transmitter
//   xstb_o  one-cycle byte strobe to the UART transmitter
//   xrdy_i  UART transmitter idle and able to take a byte
//
// Modports: slave is the serializer's view, master is the environment's view
// (controller and UART together).
interface sample_tx_if #(
    parameter int NBYTES = 4
);
    logic                  stb_i;
    logic [8*NBYTES-1:0]   data_i;
    logic [NBYTES-1:0]     dis_i;
    logic                  rdy_o;
    logic [7:0]            xdata_o;
    logic                  xstb_o;
    logic                  xrdy_i;

    modport slave (
        input  stb_i,
        input  data_i,
        input  dis_i,
        input  xrdy_i,
        output rdy_o,
        output xdata_o,
        output xstb_o
    );

    modport master (
        output stb_i,
        output data_i,
        output dis_i,
        output xrdy_i,
        input  rdy_o,
        input  xdata_o,
        input  xstb_o
    );
endinterface

// File: rtl/sample_tx.sv
// Sample word to byte serializer: sends enabled bytes of a word LSB first to the UART.
// Latency: first byte strobe 1 cycle after word accept; 2k+1 cycles per word of k bytes.
// Backpressure: rdy_o low while busy (extra strobes dropped); waits in SEND while xrdy_i=0.
//
// Ports:
//   clk_i   system clock, rising edge
//   rst_in  asynchronous active-low reset
//   bus     sample_tx_if slave modport (word in, byte out, see the interface file)
module sample_tx #(
    parameter int NBYTES = 4
) (
    input  logic       clk_i,
    input  logic       rst_in,
    sample_tx_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [8*NBYTES-1:0]   word_q,  word_d;
    logic [NBYTES-1:0]     pend_q,  pend_d;
    logic [7:0]            xdata_q, xdata_d;
    logic                  xstb_q,  xstb_d;

    // Lowest pending byte, as a one-hot mask, and the byte it selects.
    logic [NBYTES-1:0]     low_bit;
    logic [7:0]            sel_byte;

    // x & -x isolates the lowest set bit; bytes therefore leave LSB first.
    always_comb begin
        low_bit  = pend_q & (~pend_q + NBYTES'(1));
        sel_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (low_bit[i]) begin
                sel_byte = word_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        pend_d  = pend_q;
        xdata_d = xdata_q;
        // Byte strobe is a single-cycle pulse; only the SEND issue path raises it.
        xstb_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.stb_i) begin
                    word_d  = bus.data_i;
                    pend_d  = ~bus.dis_i;
                    state_d = SEND;
                end
            end

            SEND: begin
                // A fully disabled word lands here with nothing pending and
                // returns to IDLE after one busy cycle without a strobe.
                if (pend_q == '0) begin
                    state_d = IDLE;
                end else if (bus.xrdy_i) begin
                    xdata_d = sel_byte;
                    xstb_d  = 1'b1;
                    pend_d  = pend_q & ~low_bit;
                    state_d = GAP;
                end
            end

            // The UART needs a cycle to drop its ready after a strobe, so
            // xrdy_i is not trusted here.
            GAP: begin
                state_d = SEND;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            word_q  <= '0;
            pend_q  <= '0;
            xdata_q <= 8'h00;
            xstb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            pend_q  <= pend_d;
            xdata_q <= xdata_d;
            xstb_q  <= xstb_d;
        end
    end

    assign bus.rdy_o   = (state_q == IDLE);
    assign bus.xdata_o = xdata_q;
    assign bus.xstb_o  = xstb_q;

endmodule

// File: tb/tb_sample_tx.sv
// Testbench for sample_tx: directed cases followed by random words with random UART stalls.
// Latency: expected strobe edges come from a timing model of the word, not from the DUT.
// Backpressure: xrdy_i pattern per edge is chosen up front and fed to both model and DUT.
module tb_sample_tx;

    localparam int NB   = 4;
    localparam int PLEN = 128;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sample_tx_if #(.NBYTES(NB)) bus();

    sample_tx #(.NBYTES(NB)) dut (
        .clk_i  (clk),
        .rst_in (rst_n),
        .bus    (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    // pat[j] is the xrdy_i value sampled on edge t0+j of the current word.
    logic       pat [PLEN];
    // Model output: edge of each byte strobe, its value, byte count, idle edge.
    int         s_edge [NB];
    logic [7:0] s_byte [NB];
    int         k;
    int         done_edge;
    // Byte the UART line is expected to be holding.
    logic [7:0] last_tx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic fill_ones();
        for (int j = 0; j < PLEN; j++) pat[j] = 1'b1;
    endtask

    // Enabled bytes go out in ascending order. Each needs the UART ready on
    // some edge no earlier than one edge after accept / two edges after the
    // previous byte; the word is finished two edges after its last byte
    // (one edge after accept if nothing is enabled).
    task automatic model(input logic [31:0] data, input logic [NB-1:0] dis);
        int e;
        e = 1;
        k = 0;
        for (int i = 0; i < NB; i++) begin
            if (!dis[i]) begin
                while (e < PLEN - 1 && !pat[e]) e++;
                s_edge[k] = e;
                s_byte[k] = data[8*i +: 8];
                k++;
                e += 2;
            end
        end
        done_edge = (k == 0) ? 1 : s_edge[k-1] + 2;
    endtask

    // Sends one word and checks every cycle until two cycles past idle.
    // busy_j >= 0 drives a rejected strobe for edge t0+busy_j+1.
    // abort_n > 0 pulses reset right after byte abort_n-1 is observed.
    task automatic run_word(input logic [31:0] data, input logic [NB-1:0] dis,
                            input int busy_j, input int abort_n, input string tag);
        int   n;
        logic exp_stb;
        model(data, dis);
        if (busy_j >= done_edge) busy_j = -1;
        @(negedge clk);
        check({tag, " rdy_before"}, {31'd0, bus.rdy_o}, 32'd1);
        bus.stb_i  = 1'b1;
        bus.data_i = data;
        bus.dis_i  = dis;
        bus.xrdy_i = pat[0];
        n = 0;
        for (int j = 0; j <= done_edge + 2; j++) begin
            @(negedge clk);
            exp_stb = (n < k) && (s_edge[n] == j);
            if (exp_stb) last_tx = s_byte[n];
            check($sformatf("%s xstb@t0+%0d", tag, j), {31'd0, bus.xstb_o}, {31'd0, exp_stb});
            check($sformatf("%s rdy@t0+%0d", tag, j), {31'd0, bus.rdy_o}, {31'd0, (j >= done_edge)});
            check($sformatf("%s xdata@t0+%0d", tag, j), {24'd0, bus.xdata_o}, {24'd0, last_tx});
            if (exp_stb) n++;
            if (abort_n > 0 && exp_stb && n == abort_n) begin
                bus.stb_i  = 1'b0;
                bus.xrdy_i = 1'b1;
                rst_n = 1'b0;
                #1;
                last_tx = 8'h00;
                check({tag, " rst rdy"},   {31'd0, bus.rdy_o},  32'd1);
                check({tag, " rst xstb"},  {31'd0, bus.xstb_o}, 32'd0);
                check({tag, " rst xdata"}, {24'd0, bus.xdata_o}, 32'd0);
                #2;
                rst_n = 1'b1;
                return;
            end
            bus.stb_i  = (j == busy_j);
            bus.data_i = (j == busy_j) ? 32'h12345678 : data;
            bus.dis_i  = '0;
            bus.xrdy_i = pat[j+1];
        end
        bus.stb_i = 1'b0;
    endtask

    task automatic idle(input int cycles, input string tag);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check($sformatf("%s xstb idle%0d", tag, c), {31'd0, bus.xstb_o}, 32'd0);
            check($sformatf("%s rdy idle%0d", tag, c), {31'd0, bus.rdy_o}, 32'd1);
            check($sformatf("%s xdata idle%0d", tag, c), {24'd0, bus.xdata_o}, {24'd0, last_tx});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]   rdata;
        logic [NB-1:0] rdis;
        int            rbusy;

        rst_n      = 1'b0;
        bus.stb_i  = 1'b0;
        bus.data_i = '0;
        bus.dis_i  = '0;
        bus.xrdy_i = 1'b1;
        last_tx    = 8'h00;

        // Reset values must be visible before the first clock edge.
        #1;
        check("reset rdy",   {31'd0, bus.rdy_o},   32'd1);
        check("reset xstb",  {31'd0, bus.xstb_o},  32'd0);
        check("reset xdata", {24'd0, bus.xdata_o}, 32'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, "post_reset");

        fill_ones();
        run_word(32'hDDCCBBAA, 4'h0, -1, 0, "full");

        fill_ones();
        run_word(32'h44332211, 4'h5, -1, 0, "masked");

        fill_ones();
        run_word(32'h99887766, 4'hF, -1, 0, "all_off");

        // UART busy on the five SEND edges following the first gap.
        fill_ones();
        for (int j = 3; j <= 7; j++) pat[j] = 1'b0;
        run_word(32'h87654321, 4'h0, -1, 0, "stall");

        fill_ones();
        run_word(32'hA1B2C3D4, 4'h0, 2, 0, "busy");
        idle(4, "after_busy");

        fill_ones();
        run_word(32'hCAFEF00D, 4'h0, -1, 2, "abort");
        idle(6, "after_abort");
        fill_ones();
        run_word(32'h0BADBEEF, 4'h0, -1, 0, "post_abort");

        for (int w = 0; w < 30; w++) begin
            rdata = $urandom;
            rdis  = NB'($urandom_range(0, (1 << NB) - 1));
            rbusy = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4)) : -1;
            fill_ones();
            for (int j = 0; j < 40; j++) pat[j] = ($urandom_range(0, 3) != 0);
            run_word(rdata, rdis, rbusy, 0, $sformatf("rand%0d", w));
        end
        idle(3, "final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
